// File: rtl/cache_controller_if.sv
// cache_controller_if: CPU, cache and memory-side signals of the cache controller
interface cache_controller_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_busy;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wdata;
  logic              cache_write;
  logic              cache_read;
  logic              cache_move;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cache_hit, cache_rdata, mem_ack,
    output cpu_rdata, cpu_done, cpu_busy, cache_addr, cache_wdata, cache_write, cache_read,
           cache_move, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cache_hit, cache_rdata, mem_ack,
    input  cpu_rdata, cpu_done, cpu_busy, cache_addr, cache_wdata, cache_write, cache_read,
           cache_move, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped write-through, no-write-allocate cache controller
// with 4-word line refill and saturating hit/miss statistics.
module cache_controller #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  cache_controller_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, MEM_WRITE, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              we_q, we_d, relook_q, relook_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]  hit_q, hit_d, miss_q, miss_d;
  logic              lookup, refill, memw;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    relook_d = relook_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    case (state_q)
      IDLE: if (bus.cpu_rd || bus.cpu_wr) begin
        state_d  = LOOKUP;
        addr_d   = bus.cpu_addr;
        wdata_d  = bus.cpu_wdata;
        we_d     = bus.cpu_wr;
        relook_d = 1'b0;
      end
      LOOKUP: begin
        relook_d = 1'b0;
        // the lookup that follows a refill was already counted as a miss
        if (!relook_q) begin
          hit_d  = bus.cache_hit ? hit_q + CNT_W'(~&hit_q) : hit_q;
          miss_d = bus.cache_hit ? miss_q : miss_q + CNT_W'(~&miss_q);
        end
        if (we_q) state_d = MEM_WRITE;
        else if (bus.cache_hit) begin
          rdata_d = bus.cache_rdata;
          state_d = DONE;
        end else begin
          cnt_d   = 2'd0;
          state_d = REFILL;
        end
      end
      REFILL: if (bus.mem_ack) begin
        cnt_d = cnt_q + 2'd1;
        if (&cnt_q) begin
          state_d  = LOOKUP;
          relook_d = 1'b1;
        end
      end
      MEM_WRITE: state_d = bus.mem_ack ? DONE : MEM_WRITE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      relook_q <= 1'b0;
      cnt_q    <= 2'd0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      relook_q <= relook_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end
  assign lookup          = state_q == LOOKUP;
  assign refill          = state_q == REFILL;
  assign memw            = state_q == MEM_WRITE;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.cpu_done    = state_q == DONE;
  assign bus.cpu_busy    = state_q != IDLE;
  assign bus.cache_addr  = addr_q;
  assign bus.cache_wdata = wdata_q;
  assign bus.cache_read  = lookup;
  assign bus.cache_write = lookup && we_q && bus.cache_hit;
  assign bus.cache_move  = refill && bus.mem_ack;
  assign bus.mem_req     = refill || memw;
  assign bus.mem_we      = memw;
  assign bus.mem_addr    = refill ? {addr_q[ADDR_W-1:2], cnt_q} : addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.hit_count   = hit_q;
  assign bus.miss_count  = miss_q;
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: randomized scoreboard bench with a line-level reference model,
// an external direct-mapped cache model and a randomly-stalling memory.
module tb_cache_controller;
  localparam int AW = 10, DW = 32, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct {
    logic        rd;
    logic [31:0] rdata;
    int          hits, misses, done_cyc, moves, cw, wacks;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  cache_controller_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus();
  cache_controller #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [2:0]  c_tag [32];
  logic        c_val [32];
  logic [31:0] c_dat [32][4];
  logic [31:0] mem_model [1024];
  logic [31:0] ref_mem [1024];
  logic [2:0]  r_tag [32];
  logic        r_val [32];
  int          r_hits = 0, r_miss = 0;
  logic        ack_r = 1'b0, stray_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  exp_t        sb [$];
  int          n_chk = 0, n_pass = 0, cyc = 0, done_seen = 0;
  int          n_move = 0, n_cw = 0, n_wack = 0, n_req = 0;
  logic [1:0]  exp_off = 2'd0;
  logic [9:0]  cur_addr = '0;
  logic [31:0] cur_data = '0;
  assign bus.cache_hit   = c_val[bus.cache_addr[6:2]] && c_tag[bus.cache_addr[6:2]] == bus.cache_addr[9:7];
  assign bus.cache_rdata = c_dat[bus.cache_addr[6:2]][bus.cache_addr[1:0]];
  assign bus.mem_ack     = ack_r | stray_ack;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  always @(posedge clk) cyc++;
  initial forever begin
    @(posedge clk);
    #1;
    ack_r     = bus.mem_req && ($urandom_range(0, 2) == 0);
    mem_rdata = ack_r ? mem_model[bus.mem_addr] : 32'h0;
  end
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.mem_req) n_req++;
      if (bus.cache_write) begin
        check("excl", {bus.cache_move, bus.mem_req}, 0);
        n_cw++;
        c_dat[bus.cache_addr[6:2]][bus.cache_addr[1:0]] = bus.cache_wdata;
      end
      if (bus.cache_move) begin
        check("refill_off", bus.mem_addr[1:0], exp_off);
        check("refill_line", bus.mem_addr[9:2], cur_addr[9:2]);
        if (bus.mem_addr[1:0] == 2'd0) c_val[bus.mem_addr[6:2]] = 1'b0;
        c_dat[bus.mem_addr[6:2]][bus.mem_addr[1:0]] = mem_rdata;
        if (bus.mem_addr[1:0] == 2'd3) begin
          c_val[bus.mem_addr[6:2]] = 1'b1;
          c_tag[bus.mem_addr[6:2]] = bus.mem_addr[9:7];
        end
        exp_off++;
        n_move++;
      end
      if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
        check("wr_addr", bus.mem_addr, cur_addr);
        check("wr_data", bus.mem_wdata, cur_data);
        mem_model[bus.mem_addr] = bus.mem_wdata;
        n_wack++;
      end
      if (bus.cpu_done) begin
        done_seen++;
        if (sb.size() == 0) check("sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          if (e.rd) check("rdata", bus.cpu_rdata, e.rdata);
          check("hit_count", bus.hit_count, e.hits);
          check("miss_count", bus.miss_count, e.misses);
          if (e.done_cyc >= 0) check("hit_latency", cyc, e.done_cyc);
          check("moves", n_move, e.moves);
          check("cache_writes", n_cw, e.cw);
          check("mem_writes", n_wack, e.wacks);
          if (e.moves == 0 && e.wacks == 0) check("no_mem_req", n_req, 0);
        end
      end
    end
  end
  task automatic issue(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
    exp_t e;
    int k;
    logic hit;
    @(negedge clk);
    k = 0;
    while (bus.cpu_busy && k < 300) begin @(negedge clk); k++; end
    hit = r_val[a[6:2]] && r_tag[a[6:2]] == a[9:7];
    if (hit) r_hits = (r_hits < CMAX) ? r_hits + 1 : CMAX;
    else     r_miss = (r_miss < CMAX) ? r_miss + 1 : CMAX;
    e.rd = !wr;
    e.rdata = ref_mem[a];
    e.hits = r_hits;
    e.misses = r_miss;
    e.done_cyc = (!wr && hit) ? cyc + 2 : -1;
    e.moves = (!wr && !hit) ? 4 : 0;
    e.cw = (wr && hit) ? 1 : 0;
    e.wacks = wr ? 1 : 0;
    if (wr) ref_mem[a] = d;
    else if (!hit) begin r_val[a[6:2]] = 1'b1; r_tag[a[6:2]] = a[9:7]; end
    sb.push_back(e);
    cur_addr = a; cur_data = d;
    n_move = 0; n_cw = 0; n_wack = 0; n_req = 0; exp_off = 2'd0;
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(negedge clk);
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
  endtask
  task automatic do_req(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
    int seen, k;
    seen = done_seen;
    issue(rd, wr, a, d);
    k = 0;
    while (done_seen == seen && k < 300) begin @(negedge clk); k++; end
    if (done_seen == seen) check("done_timeout", 0, 1);
  endtask
  initial begin
    int k;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int i = 0; i < 32; i++) begin c_val[i] = 1'b0; r_val[i] = 1'b0; c_tag[i] = '0; r_tag[i] = '0; end
    for (int i = 0; i < 1024; i++) begin mem_model[i] = $urandom; ref_mem[i] = mem_model[i]; end
    for (int i = 0; i < 4; i++) begin mem_model[32'h84 + i] = 32'hA0 + i; ref_mem[32'h84 + i] = 32'hA0 + i; end
    #12;
    check("rst_busy", bus.cpu_busy, 0);
    check("rst_done", bus.cpu_done, 0);
    check("rst_outs", {bus.mem_req, bus.cache_write, bus.cache_move, bus.cache_read}, 0);
    check("rst_counts", {bus.hit_count, bus.miss_count, bus.cpu_rdata}, 0);
    @(negedge clk) rst = 1'b0;
    do_req(1, 0, 10'h085, 0);
    do_req(1, 0, 10'h087, 0);
    do_req(0, 1, 10'h086, 32'h55);
    do_req(1, 0, 10'h086, 0);
    do_req(0, 1, 10'h300, 32'hDEAD_BEEF);
    do_req(1, 0, 10'h300, 0);
    do_req(1, 1, 10'h302, 32'h1234_5678);
    do_req(1, 0, 10'h302, 0);
    @(negedge clk) stray_ack = 1'b1;
    @(negedge clk) stray_ack = 1'b0;
    check("stray_busy", bus.cpu_busy, 0);
    check("stray_req", bus.mem_req, 0);
    check("stray_hits", bus.hit_count, r_hits);
    issue(1, 0, 10'h1A4, 0);
    k = 0;
    while (n_move < 2 && k < 300) begin @(negedge clk); k++; end
    if (n_move < 2) check("abort_timeout", n_move, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_outs", {bus.mem_req, bus.cache_move, bus.cache_write, bus.cpu_busy, bus.cpu_done}, 0);
    check("abort_counts", {bus.hit_count, bus.miss_count, bus.cpu_rdata}, 0);
    sb.delete();
    r_val[5'd9] = 1'b0;
    r_hits = 0; r_miss = 0;
    @(negedge clk) rst = 1'b0;
    do_req(1, 0, 10'h1A4, 0);
    do_req(1, 0, 10'h1A5, 0);
    for (int i = 0; i < 60; i++) begin
      logic [9:0] a;
      logic rd;
      a = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      rd = $urandom_range(0, 2) != 0;
      do_req(rd, !rd, a, $urandom);
    end
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
